alu_seq_ctrl: RTL and testbench

Moore FSM sequencer for the multi-cycle ALU datapath. Accepts an op on a start/done handshake and drives operand loads, add/sub/shift/restore enables, and the shared iteration counter (counter_struct) through clear and count-up strobes. Supports add, subtract, radix-2 shift-add multiply and restoring divide. Sits between the top-level ALU control inputs and the accumulator/quotient registers plus the iteration counter.

---
 rtl/alu_seq_ctrl_pkg.sv | 23 ++
 rtl/alu_seq_ctrl.sv | 99 +++++++++
 tb/tb_alu_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - op codes and FSM state encoding for the multi-cycle ALU sequencer
package alu_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_ADDSUB    = 4'd2,
        ST_MUL_ADD   = 4'd3,
        ST_MUL_SHIFT = 4'd4,
        ST_DIV_SHIFT = 4'd5,
        ST_DIV_SUB   = 4'd6,
        ST_DIV_CHK   = 4'd7,
        ST_DONE      = 4'd8
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - Moore sequencer for add/sub, shift-add multiply and restoring divide
import alu_seq_ctrl_pkg::*;

module alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] cnt,
    input  logic             q_lsb,
    input  logic             acc_msb,
    input  logic             b_zero,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ld_a,
    output logic             ld_b,
    output logic             cnt_clr,
    output logic             cnt_up,
    output logic             add_en,
    output logic             sub_en,
    output logic             shift_en,
    output logic             restore_en,
    output logic             set_q
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e state_q, state_d;
    op_e    op_q;
    logic   busy_q, done_q, err_q, ld_q, cnt_up_q, add_q, sub_q, shift_q;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:      state_d = start ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                if (op_q == OP_DIV && b_zero) state_d = ST_DONE;
                else if (op_q == OP_MUL)      state_d = ST_MUL_ADD;
                else if (op_q == OP_DIV)      state_d = ST_DIV_SHIFT;
                else                          state_d = ST_ADDSUB;
            end
            ST_ADDSUB:    state_d = ST_DONE;
            ST_MUL_ADD:   state_d = ST_MUL_SHIFT;
            ST_MUL_SHIFT: state_d = (cnt == LAST_ITER) ? ST_DONE : ST_MUL_ADD;
            ST_DIV_SHIFT: state_d = ST_DIV_SUB;
            ST_DIV_SUB:   state_d = ST_DIV_CHK;
            ST_DIV_CHK:   state_d = (cnt == LAST_ITER) ? ST_DONE : ST_DIV_SHIFT;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ld_q     <= 1'b0;
            cnt_up_q <= 1'b0;
            add_q    <= 1'b0;
            sub_q    <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) op_q <= op_e'(op);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            err_q    <= (state_q == ST_LOAD) && (op_q == OP_DIV) && b_zero;
            ld_q     <= (state_d == ST_LOAD);
            cnt_up_q <= (state_d == ST_MUL_SHIFT) || (state_d == ST_DIV_CHK);
            shift_q  <= (state_d == ST_MUL_SHIFT) || (state_d == ST_DIV_SHIFT);
            add_q    <= (state_d == ST_ADDSUB) && (op_q == OP_ADD);
            sub_q    <= (state_d == ST_DIV_SUB) ||
                        ((state_d == ST_ADDSUB) && (op_q == OP_SUB));
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign ld_a       = ld_q;
    assign ld_b       = ld_q;
    assign cnt_clr    = ld_q;
    assign cnt_up     = cnt_up_q;
    assign shift_en   = shift_q;
    assign sub_en     = sub_q;
    // Data-dependent strobes follow the live datapath flags within the state.
    assign add_en     = add_q || ((state_q == ST_MUL_ADD) && q_lsb);
    assign restore_en = (state_q == ST_DIV_CHK) && acc_msb;
    assign set_q      = (state_q == ST_DIV_CHK) && !acc_msb;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with a behavioural iteration counter
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int W  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op_r;
    logic [CW-1:0] cnt;
    logic          q_lsb, acc_msb, b_zero;
    logic          busy, done, err, ld_a, ld_b, cnt_clr, cnt_up;
    logic          add_en, sub_en, shift_en, restore_en, set_q;
    logic [15:0]   qbits, abits;
    logic [11:0]   outs;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op_r), .cnt(cnt),
        .q_lsb(q_lsb), .acc_msb(acc_msb), .b_zero(b_zero),
        .busy(busy), .done(done), .err(err), .ld_a(ld_a), .ld_b(ld_b),
        .cnt_clr(cnt_clr), .cnt_up(cnt_up), .add_en(add_en), .sub_en(sub_en),
        .shift_en(shift_en), .restore_en(restore_en), .set_q(set_q)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset)       cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_up)  cnt <= cnt + 1'b1;
    end

    assign q_lsb   = qbits[cnt];
    assign acc_msb = abits[cnt];
    assign outs    = {busy, done, err, ld_a, ld_b, cnt_clr, cnt_up,
                      add_en, sub_en, shift_en, restore_en, set_q};

    typedef struct {
        int lat; int err; int ncnt; int nadd; int nsub; int nshift;
        int nrest; int nsetq; int nld; int fcnt;
    } exp_t;

    exp_t sb[$];
    exp_t acc_m, e_m;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, int act, int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endfunction

    function automatic exp_t model(logic [1:0] op, bit bz, logic [15:0] qb, logic [15:0] ab);
        exp_t e = '{default: 0};
        int ones_q = 0;
        int ones_a = 0;
        for (int i = 0; i < W; i++) begin
            ones_q += int'(qb[i]);
            ones_a += int'(ab[i]);
        end
        e.nld = 1;
        case (op)
            2'b00: begin e.lat = 3; e.nadd = 1; end
            2'b01: begin e.lat = 3; e.nsub = 1; end
            2'b10: begin
                e.lat = 2 + 2 * W; e.ncnt = W; e.nshift = W; e.nadd = ones_q; e.fcnt = W;
            end
            default: begin
                if (bz) begin
                    e.lat = 2; e.err = 1;
                end else begin
                    e.lat = 2 + 3 * W; e.ncnt = W; e.nshift = W; e.nsub = W;
                    e.nrest = ones_a; e.nsetq = W - ones_a; e.fcnt = W;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            acc_m = '{default: 0};
        end else if (busy) begin
            acc_m.lat++;
            acc_m.ncnt   += int'(cnt_up);
            acc_m.nadd   += int'(add_en);
            acc_m.nsub   += int'(sub_en);
            acc_m.nshift += int'(shift_en);
            acc_m.nrest  += int'(restore_en);
            acc_m.nsetq  += int'(set_q);
            acc_m.nld    += int'(ld_a & ld_b & cnt_clr);
            if (err && !done) chk("err_outside_done", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e_m = sb.pop_front();
                    chk("latency",    acc_m.lat,    e_m.lat);
                    chk("err",        int'(err),    e_m.err);
                    chk("cnt_up",     acc_m.ncnt,   e_m.ncnt);
                    chk("add_en",     acc_m.nadd,   e_m.nadd);
                    chk("sub_en",     acc_m.nsub,   e_m.nsub);
                    chk("shift_en",   acc_m.nshift, e_m.nshift);
                    chk("restore_en", acc_m.nrest,  e_m.nrest);
                    chk("set_q",      acc_m.nsetq,  e_m.nsetq);
                    chk("load",       acc_m.nld,    e_m.nld);
                    chk("final_cnt",  int'(cnt),    e_m.fcnt);
                end
                acc_m = '{default: 0};
            end
        end else if (outs != '0) begin
            chk("idle_outputs", int'(outs), 0);
        end
    end

    task automatic do_op(input logic [1:0] op, input bit bz, input logic [15:0] qb,
                         input logic [15:0] ab, input bit hold, input bit rnd);
        int t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        op_r = op; b_zero = bz; qbits = qb; abits = ab; start = 1'b1;
        sb.push_back(model(op, bz, qb, ab));
        @(posedge clk); #1;
        chk("load_after_start", int'(ld_a & busy), 1);
        if (!hold) start = 1'b0;
        t = 0;
        while (!done && t < 100) begin
            if (!hold && rnd) start = 1'($urandom % 2);
            @(posedge clk); #1; t++;
        end
        if (!done) chk("done_timeout", 0, 1);
        if (!hold && rnd) start = 1'($urandom % 2);
        @(posedge clk); #1;
        chk("idle_after_done", int'(busy), 0);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit hold;
        reset = 1'b0; start = 1'b0; op_r = 2'b00; b_zero = 1'b0;
        qbits = '0; abits = '0;
        #3;
        chk("reset_state", int'(outs), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        do_op(OP_ADD, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        do_op(OP_MUL, 1'b0, 16'b1101, 16'h0, 1'b0, 1'b0);
        do_op(OP_DIV, 1'b0, 16'h0, 16'b1001, 1'b0, 1'b0);
        do_op(OP_DIV, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        op_r = OP_MUL; qbits = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2;
        reset = 1'b0;
        #1;
        chk("reset_abort_outputs", int'(outs), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", int'(done | busy), 0);
        end

        do_op(OP_SUB, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        do_op(OP_ADD, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        start = 1'b0;

        repeat (40) begin
            hold = 1'($urandom % 2);
            do_op(2'($urandom % 4), ($urandom % 4) == 0, 16'($urandom), 16'($urandom), hold, 1'b1);
            start = 1'b0;
            repeat ($urandom % 3) begin @(posedge clk); #1; end
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
